// File: rtl/bubble_sorter_n_pkg.sv
// Shared types for the serial bubble sorter: FSM state encoding and a
// ceil-log2 helper that sizes the pass/index counters.
package bubble_sort_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SORT = 1'b1
  } state_e;

  // Never returns less than 1 so a counter always has at least one bit.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/bubble_sorter_n_if.sv
// Parallel job interface of the bubble sorter. master = data producer,
// slave = sorter.
//
// Handshake: start is a request that is taken on a rising edge only while
// busy=0; a request seen while busy=1 is dropped, not queued. descend and din
// are sampled on that same edge. done pulses for one cycle when the result
// lands, and valid stays high while dout holds that result.
interface bubble_sorter_n_if #(
  parameter int WIDTH = 8,
  parameter int N     = 4
);
  logic               start;
  logic               descend;
  logic [N*WIDTH-1:0] din;
  logic               busy;
  logic               done;
  logic               valid;
  logic [N*WIDTH-1:0] dout;

  modport master (output start, descend, din, input busy, done, valid, dout);
  modport slave  (input start, descend, din, output busy, done, valid, dout);
endinterface

// File: rtl/bubble_sorter_n_compare_swap_cell.sv
// Combinational compare-swap of one adjacent pair. Equal values pass straight
// through, which keeps the sort stable.
module compare_swap_cell #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             descend,
  output logic [WIDTH-1:0] lo_out,
  output logic [WIDTH-1:0] hi_out,
  output logic             swapped
);
  assign swapped = descend ? (a < b) : (a > b);
  assign lo_out  = swapped ? b : a;
  assign hi_out  = swapped ? a : b;
endmodule

// File: rtl/bubble_sorter_n.sv
// Serial N-lane bubble sorter, one adjacent compare-swap per clock.
// Optional feature: define BUBBLE_EARLY_EXIT_EN to finish after a swap-free pass.
module bubble_sorter_n
  import bubble_sort_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N     = 4
) (
  input  logic               clk,
  input  logic               rst,
  bubble_sorter_n_if.slave   bus,
  output state_e             dbg_state_o
);
  localparam int            CW     = clog2(N);
  localparam logic [CW-1:0] LAST_P = CW'(N - 2);

  state_e           state_q;
  logic [WIDTH-1:0] a_q [N];
  logic [CW-1:0]    p_q;
  logic [CW-1:0]    j_q;
  logic             desc_q;
  logic             busy_q;
  logic             done_q;
  logic             valid_q;

  logic [CW-1:0]    j_nxt;
  logic [CW-1:0]    last_j;
  logic [WIDTH-1:0] lo_d;
  logic [WIDTH-1:0] hi_d;
  logic             swapped;
  logic             pass_end;
  logic             finish;

  assign j_nxt    = j_q + CW'(1);
  assign last_j   = LAST_P - p_q;
  assign pass_end = (j_q == last_j);

`ifdef BUBBLE_EARLY_EXIT_EN
  logic swap_q;
  // The current compare counts toward the pass's swap history.
  assign finish = pass_end && ((p_q == LAST_P) || !(swap_q || swapped));
`else
  logic unused_swapped;
  assign unused_swapped = swapped;
  assign finish = pass_end && (p_q == LAST_P);
`endif

  compare_swap_cell #(.WIDTH(WIDTH)) u_cell (
    .a       (a_q[j_q]),
    .b       (a_q[j_nxt]),
    .descend (desc_q),
    .lo_out  (lo_d),
    .hi_out  (hi_d),
    .swapped (swapped)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      p_q     <= '0;
      j_q     <= '0;
      desc_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      for (int i = 0; i < N; i++) a_q[i] <= '0;
`ifdef BUBBLE_EARLY_EXIT_EN
      swap_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            for (int i = 0; i < N; i++) a_q[i] <= bus.din[i*WIDTH +: WIDTH];
            desc_q  <= bus.descend;
            p_q     <= '0;
            j_q     <= '0;
            busy_q  <= 1'b1;
            valid_q <= 1'b0;
            state_q <= SORT;
`ifdef BUBBLE_EARLY_EXIT_EN
            swap_q  <= 1'b0;
`endif
          end
        end
        SORT: begin
          a_q[j_q]   <= lo_d;
          a_q[j_nxt] <= hi_d;
          if (pass_end) begin
            j_q <= '0;
            p_q <= p_q + CW'(1);
`ifdef BUBBLE_EARLY_EXIT_EN
            swap_q <= 1'b0;
`endif
          end else begin
            j_q <= j_nxt;
`ifdef BUBBLE_EARLY_EXIT_EN
            swap_q <= swap_q | swapped;
`endif
          end
          if (finish) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            valid_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // dout mirrors the working array; it is only stable once valid is set.
  for (genvar g = 0; g < N; g++) begin : g_dout
    assign bus.dout[g*WIDTH +: WIDTH] = a_q[g];
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.valid   = valid_q;
  assign dbg_state_o = state_q;

endmodule
